uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered UART transmitter: circular FIFO feeding a start/data/stop serializer

module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A write into a full buffer is silently dropped; a pop never underflows.
    assign do_push = push && (count != DEPTH_CNT);
    assign do_pop  = pop && (count != '0);

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

module uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tx_en_i,
    input  logic                  tx_wen_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  tx_bit_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  busy_o
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BCW      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int DCW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [DCW-1:0] BIT_LAST  = DCW'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]            state;
    logic [BCW-1:0]        baud_cnt;
    logic [DCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic                  tx_bit;
    logic                  en_q;
    logic                  baud_wrap;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic                  fifo_full;
    logic                  fifo_empty;

    // The enable goes through one register so a frame begins two clocks after
    // the buffer becomes eligible, whether that is by a write or by re-enabling.
    assign pop        = (state == S_IDLE) && en_q && !fifo_empty;
    assign baud_wrap  = (baud_cnt == BAUD_LAST);
    assign shreg_next = shreg >> 1;

    assign tx_bit_o = tx_bit;
    assign full_o   = fifo_full;
    assign empty_o  = fifo_empty;
    assign busy_o   = (state != S_IDLE);

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (tx_wen_i),
        .push_data (din_i),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Registered copy of the enable; dropping it never disturbs a frame in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q <= 1'b0;
        end else begin
            en_q <= tx_en_i;
        end
    end

    // Frame sequencer: line level, state and counters all move on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_bit   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_bit   <= 1'b1;
                    if (pop) begin
                        shreg  <= head;
                        state  <= S_START;
                        tx_bit <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                        tx_bit   <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BCW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= S_STOP;
                            tx_bit  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + DCW'(1);
                            shreg   <= shreg_next;
                            tx_bit  <= shreg_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BCW'(1);
                    end
                end
                default: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BCW'(1);
                    end
                    tx_bit <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized, model-checked bench for uart_tx

module tb_uart_tx;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int DIV_A = 50_000_000 / 115_200;
    localparam int DIV_B = 50_000_000 / 12_500_000;
    localparam int FR_A  = (W + 2) * DIV_A;
    localparam int FR_B  = (W + 2) * DIV_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n   [2];
    logic         en      [2];
    logic         wen     [2];
    logic [W-1:0] din     [2];
    logic         tx_l    [2];
    logic         busy_l  [2];
    logic         empty_l [2];
    logic         full_l  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model state: FIFO as a head-first list, frame as elapsed cycles since start
    logic [W-1:0] mbuf [2][DEPTH];
    int           mcnt [2];
    int           mph  [2];
    logic [W-1:0] mcur [2];
    logic         men  [2];

    logic [W-1:0] rxq0 [$];
    logic [W-1:0] rxq1 [$];
    int           rxt0 [$];
    int           rxt1 [$];

    uart_tx u_a (
        .clk_i    (clk),
        .rst_ni   (rst_n[0]),
        .tx_en_i  (en[0]),
        .tx_wen_i (wen[0]),
        .din_i    (din[0]),
        .tx_bit_o (tx_l[0]),
        .full_o   (full_l[0]),
        .empty_o  (empty_l[0]),
        .busy_o   (busy_l[0])
    );

    uart_tx #(
        .CLK_FREQ   (50_000_000),
        .BAUD_RATE  (12_500_000),
        .DATA_WIDTH (W),
        .FIFO_DEPTH (DEPTH)
    ) u_b (
        .clk_i    (clk),
        .rst_ni   (rst_n[1]),
        .tx_en_i  (en[1]),
        .tx_wen_i (wen[1]),
        .din_i    (din[1]),
        .tx_bit_o (tx_l[1]),
        .full_o   (full_l[1]),
        .empty_o  (empty_l[1]),
        .busy_o   (busy_l[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_tx(int i);
        int b;
        if (mph[i] < 0) return 1'b1;
        b = mph[i] / div_of(i);
        if (b == 0) return 1'b0;
        if (b <= W) return mcur[i][b-1];
        return 1'b1;
    endfunction

    task automatic model_step(int i);
        bit pop_now;
        bit push_now;
        if (rst_n[i] !== 1'b1) begin
            mcnt[i] = 0;
            mph[i]  = -1;
            men[i]  = 1'b0;
            return;
        end
        pop_now  = (mph[i] < 0) && (men[i] == 1'b1) && (mcnt[i] > 0);
        push_now = (wen[i] == 1'b1) && (mcnt[i] < DEPTH);
        if (mph[i] >= 0) begin
            mph[i]++;
            if (mph[i] == (W + 2) * div_of(i)) mph[i] = -1;
        end else if (pop_now) begin
            mph[i]  = 0;
            mcur[i] = mbuf[i][0];
        end
        if (pop_now) begin
            for (int k = 0; k < DEPTH - 1; k++) mbuf[i][k] = mbuf[i][k+1];
            mcnt[i]--;
        end
        if (push_now) begin
            mbuf[i][mcnt[i]] = din[i];
            mcnt[i]++;
        end
        men[i] = en[i];
    endtask

    initial begin
        mph[0] = -1; mph[1] = -1;
        mcnt[0] = 0; mcnt[1] = 0;
        men[0] = 1'b0; men[1] = 1'b0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst_n[i] !== 1'b1) begin
                    check($sformatf("rst_line%0d", i),  tx_l[i],    1'b1);
                    check($sformatf("rst_busy%0d", i),  busy_l[i],  1'b0);
                    check($sformatf("rst_empty%0d", i), empty_l[i], 1'b1);
                    check($sformatf("rst_full%0d", i),  full_l[i],  1'b0);
                end else begin
                    check($sformatf("line%0d", i),  tx_l[i],    exp_tx(i));
                    check($sformatf("busy%0d", i),  busy_l[i],  mph[i] >= 0);
                    check($sformatf("empty%0d", i), empty_l[i], mcnt[i] == 0);
                    check($sformatf("full%0d", i),  full_l[i],  mcnt[i] == DEPTH);
                end
            end
        end
    end

    task automatic rx_wait(int i, int n, output bit hit_rst);
        hit_rst = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (rst_n[i] !== 1'b1) hit_rst = 1'b1;
        end
    endtask

    // mid-bit sampling receiver standing in for the loopback UART receiver
    task automatic rx_run(int i);
        logic         prev;
        logic [W-1:0] b;
        bit           ok;
        bit           r;
        int           t0;
        prev = 1'b1;
        b    = '0;
        forever begin
            @(negedge clk);
            if (rst_n[i] === 1'b1 && prev === 1'b1 && tx_l[i] === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                rx_wait(i, div_of(i) / 2, r);
                if (r || tx_l[i] !== 1'b0) ok = 1'b0;
                for (int k = 0; k < W; k++) begin
                    rx_wait(i, div_of(i), r);
                    if (r) ok = 1'b0;
                    b[k] = tx_l[i];
                end
                rx_wait(i, div_of(i), r);
                if (r || tx_l[i] !== 1'b1) ok = 1'b0;
                if (ok) begin
                    if (i == 0) begin rxq0.push_back(b); rxt0.push_back(t0); end
                    else        begin rxq1.push_back(b); rxt1.push_back(t0); end
                end
            end
            prev = tx_l[i];
        end
    endtask

    initial rx_run(0);
    initial rx_run(1);

    function automatic int rxsize(int i);
        return (i == 0) ? rxq0.size() : rxq1.size();
    endfunction

    task automatic wait_rx(int i, int n, int bound);
        int k = 0;
        while (rxsize(i) < n && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_busy(int i, logic v, int bound);
        int k = 0;
        while (busy_l[i] !== v && k < bound) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("wait_busy%0d", i), busy_l[i], v);
    endtask

    task automatic wr(int i, logic [W-1:0] v);
        wen[i] = 1'b1;
        din[i] = v;
        @(negedge clk);
        wen[i] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int           pat [10];
        int           bcount;
        int           c;
        logic         exp_bit;
        logic [W-1:0] second;
        pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; en[i] = 1'b0; wen[i] = 1'b0; din[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_line",  tx_l[i],    1'b1);
            check("reset_busy",  busy_l[i],  1'b0);
            check("reset_empty", empty_l[i], 1'b1);
            check("reset_full",  full_l[i],  1'b0);
        end
        #1 rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(negedge clk);

        // single 0xA5 frame at default baud
        en[0] = 1'b1;
        repeat (2) @(negedge clk);
        rxq0.delete();
        wen[0] = 1'b1; din[0] = 8'hA5;
        bcount = 0;
        for (int k = 1; k <= FR_A + 100; k++) begin
            @(negedge clk);
            if (k == 1) wen[0] = 1'b0;
            if (busy_l[0] === 1'b1) bcount++;
            exp_bit = (k >= 2 && k < 2 + 4340) ? pat[(k - 2) / 434][0] : 1'b1;
            check("a5_bit", tx_l[0], exp_bit);
        end
        check("a5_busy_len", bcount, 4340);
        check("a5_rx_cnt", rxq0.size(), 1);
        if (rxq0.size() > 0) check("a5_rx", rxq0[0], 8'hA5);

        // loopback of three bytes
        rxq0.delete();
        wr(0, 8'h3C); wr(0, 8'hFF); wr(0, 8'h00);
        wait_rx(0, 3, 3 * (FR_A + 1) + 200);
        check("loop_cnt", rxq0.size(), 3);
        if (rxq0.size() >= 3) begin
            check("loop_b0", rxq0[0], 8'h3C);
            check("loop_b1", rxq0[1], 8'hFF);
            check("loop_b2", rxq0[2], 8'h00);
        end
        en[0] = 1'b0;

        // fill past capacity with transmit disabled, then drain
        en[1] = 1'b0;
        repeat (2) @(negedge clk);
        for (int v = 0; v <= 16; v++) begin
            wen[1] = 1'b1; din[1] = W'(v);
            @(negedge clk);
            if (v == 14) check("full_at15", full_l[1], 1'b0);
            if (v == 15) check("full_at16", full_l[1], 1'b1);
        end
        wen[1] = 1'b0;
        check("full_hold", full_l[1], 1'b1);
        check("full_not_empty", empty_l[1], 1'b0);
        rxq1.delete(); rxt1.delete();
        en[1] = 1'b1;
        wait_rx(1, 16, 16 * (FR_B + 1) + 100);
        repeat (100) @(negedge clk);
        check("fill_cnt", rxq1.size(), 16);
        for (int k = 0; k < rxq1.size(); k++) begin
            check("fill_byte", rxq1[k], W'(k));
            if (k > 0) check("fill_gap", rxt1[k] - rxt1[k-1], 41);
        end
        check("fill_empty", empty_l[1], 1'b1);

        // enable dropped mid-frame with a second byte queued
        rxq1.delete();
        second = W'($urandom);
        wr(1, 8'h55); wr(1, second);
        wait_busy(1, 1'b1, 20);
        repeat (17) @(negedge clk);
        en[1] = 1'b0;
        wait_busy(1, 1'b0, 60);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("hold_line", tx_l[1], 1'b1);
            check("hold_busy", busy_l[1], 1'b0);
        end
        check("hold_rx_cnt", rxq1.size(), 1);
        if (rxq1.size() > 0) check("hold_rx", rxq1[0], 8'h55);
        en[1] = 1'b1;
        c = 0;
        while (tx_l[1] !== 1'b0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("resume_lat", c, 2);
        wait_rx(1, 2, FR_B + 50);
        check("resume_cnt", rxq1.size(), 2);
        if (rxq1.size() > 1) check("resume_rx", rxq1[1], second);

        // reset during DATA with three entries queued
        repeat (10) @(negedge clk);
        for (int k = 0; k < 4; k++) wr(1, W'($urandom));
        wait_busy(1, 1'b1, 20);
        repeat (2 * DIV_B + 3) @(negedge clk);
        #1 rst_n[1] = 1'b0;
        #1;
        check("abort_line",  tx_l[1],    1'b1);
        check("abort_busy",  busy_l[1],  1'b0);
        check("abort_empty", empty_l[1], 1'b1);
        check("abort_full",  full_l[1],  1'b0);
        @(negedge clk);
        #1 rst_n[1] = 1'b1;
        rxq1.delete();
        bcount = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy_l[1] !== 1'b0) bcount++;
        end
        check("abort_no_frame", bcount, 0);
        check("abort_no_rx", rxq1.size(), 0);
        check("abort_still_empty", empty_l[1], 1'b1);

        // pop from a full buffer coinciding with a write
        en[1] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 16; k++) wr(1, W'(32 + k));
        check("race_pre_full", full_l[1], 1'b1);
        rxq1.delete();
        en[1] = 1'b1;
        @(negedge clk);
        check("race_full_before", full_l[1], 1'b1);
        wen[1] = 1'b1; din[1] = 8'hEE;
        @(negedge clk);
        wen[1] = 1'b0;
        check("race_full_after", full_l[1], 1'b0);
        check("race_busy", busy_l[1], 1'b1);
        wait_rx(1, 16, 16 * (FR_B + 1) + 100);
        repeat (60) @(negedge clk);
        check("race_cnt", rxq1.size(), 16);
        for (int k = 0; k < rxq1.size(); k++) check("race_byte", rxq1[k], W'(32 + k));
        check("race_empty", empty_l[1], 1'b1);

        // randomized traffic, checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            en[1]  = ($urandom_range(0, 7) != 0);
            wen[1] = ($urandom_range(0, 2) == 0);
            din[1] = W'($urandom);
            if ($urandom_range(0, 999) == 0) begin
                #1 rst_n[1] = 1'b0;
                @(negedge clk);
                #1 rst_n[1] = 1'b1;
            end
            @(negedge clk);
        end
        wen[1] = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
